// File: rtl/ram_io_responder.sv
// Target side of the CPU byte bus: byte RAM, UART TX/RX FIFOs, cycle counter, program stop.
// Define RAM_OOB_TRAP_EN to trap 0x20000-0x2FFFF accesses and expose the oob_error port.
module ram_io_responder #(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH       = 8,
  parameter int unsigned RX_DEPTH       = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_done,
  output logic        tx_overflow
`ifdef RAM_OOB_TRAP_EN
  ,
  output logic        oob_error
`endif
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned TxCw = TxAw + 1;
  localparam int unsigned RxCw = RxAw + 1;

  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TxAw-1:0] tx_wp_q, tx_rp_q;
  logic [TxCw-1:0] tx_cnt_q, tx_cnt_d;
  logic [RxAw-1:0] rx_wp_q, rx_rp_q;
  logic [RxCw-1:0] rx_cnt_q, rx_cnt_d;
  logic [31:0]     counter_q, snapshot_q;

  logic                      io, oob, ram_we, rd;
  logic [2:0]                offset;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      tx_push, tx_full, tx_pop, tx_wr_en, wr_stop;
  logic [7:0]                tx_push_data;
  logic                      rx_push, rx_pop, rx_empty;
  logic [7:0]                rd_data;
  logic                      unused_addr;

  assign unused_addr = ^mem_a[31:18];

  assign io      = (mem_a[17:16] == 2'b11);
`ifdef RAM_OOB_TRAP_EN
  assign oob     = (mem_a[17:16] == 2'b10);
`else
  assign oob     = 1'b0;
`endif
  assign offset  = mem_a[2:0];
  assign ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];
  assign rd      = !mem_wr;
  assign ram_we  = mem_wr && !io && !oob;

  // A stop write always emits 0x00; ordinary 0x00 writes to the data port are filtered.
  assign wr_stop      = io && mem_wr && (offset == 3'd4);
  assign tx_push      = wr_stop || (io && mem_wr && (offset == 3'd0) && (mem_dout != 8'h00));
  assign tx_push_data = wr_stop ? 8'h00 : mem_dout;
  assign tx_full      = (tx_cnt_q == TxCw'(TX_DEPTH));
  assign tx_valid     = (tx_cnt_q != '0);
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_wr_en     = tx_push && (!tx_full || tx_pop);
  assign tx_data      = tx_mem[tx_rp_q];

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_ready = (rx_cnt_q != RxCw'(RX_DEPTH));
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = io && rd && (offset == 3'd0) && !rx_empty;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_wr_en && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else if (!tx_wr_en && tx_pop) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  // Byte 0 of the counter window comes straight from the live counter; the snapshot
  // taken at the same edge serves bytes 1..3 so a 4-byte read stays coherent.
  always_comb begin
    rd_data = 8'h00;
    if (io) begin
      case (offset)
        3'd0:    rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
        3'd4:    rd_data = counter_q[7:0];
        3'd5:    rd_data = snapshot_q[15:8];
        3'd6:    rd_data = snapshot_q[23:16];
        3'd7:    rd_data = snapshot_q[31:24];
        default: rd_data = 8'h00;
      endcase
    end else if (oob) begin
      rd_data = 8'hFF;
    end else begin
      rd_data = ram[ram_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_wr_en) begin
      tx_mem[tx_wp_q] <= tx_push_data;
    end
    if (rx_push) begin
      rx_mem[rx_wp_q] <= rx_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      prog_done      <= 1'b0;
      tx_overflow    <= 1'b0;
      counter_q      <= '0;
      snapshot_q     <= '0;
      tx_wp_q        <= '0;
      tx_rp_q        <= '0;
      tx_cnt_q       <= '0;
      rx_wp_q        <= '0;
      rx_rp_q        <= '0;
      rx_cnt_q       <= '0;
    end else begin
      counter_q <= counter_q + 32'd1;
      if (rd) begin
        mem_din <= rd_data;
      end
      if (io && rd && (offset == 3'd4)) begin
        snapshot_q <= counter_q;
      end
      if (wr_stop) begin
        prog_done <= 1'b1;
      end
      if (tx_push && tx_full && !tx_pop) begin
        tx_overflow <= 1'b1;
      end
      if (tx_wr_en) begin
        tx_wp_q <= tx_wp_q + 1'b1;
      end
      if (tx_pop) begin
        tx_rp_q <= tx_rp_q + 1'b1;
      end
      tx_cnt_q       <= tx_cnt_d;
      io_buffer_full <= (tx_cnt_d >= TxCw'(TX_DEPTH - 2));
      if (rx_push) begin
        rx_wp_q <= rx_wp_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rp_q <= rx_rp_q + 1'b1;
      end
      rx_cnt_q <= rx_cnt_d;
    end
  end

`ifdef RAM_OOB_TRAP_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      oob_error <= 1'b0;
    end else if (oob) begin
      oob_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM, TX/RX FIFOs, counter snapshot, stop and reset.
module tb_ram_io_responder;

  localparam logic [31:0] Idle = 32'h0003_0002;  // write to an unused I/O offset: no effect

  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_done;
  logic        tx_overflow;
`ifdef RAM_OOB_TRAP_EN
  logic        oob_error;
`endif

  int checks = 0;
  int errors = 0;

  ram_io_responder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .prog_done      (prog_done),
    .tx_overflow    (tx_overflow)
`ifdef RAM_OOB_TRAP_EN
    ,
    .oob_error      (oob_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; results are checked at the next falling edge.
  task automatic bus_wr(input logic [31:0] addr, input logic [7:0] data);
    mem_a = addr; mem_dout = data; mem_wr = 1'b1;
    @(negedge clk);
    mem_a = Idle; mem_wr = 1'b1;
  endtask

  task automatic bus_rd(input logic [31:0] addr);
    mem_a = addr; mem_wr = 1'b0;
    @(negedge clk);
    mem_a = Idle; mem_wr = 1'b1;
  endtask

  initial begin
    rst_in = 1'b1; mem_a = Idle; mem_dout = 8'h00; mem_wr = 1'b1;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    #2 rst_in = 1'b0;
    #2;
    chk("rst_mem_din", {24'd0, mem_din}, 32'h00);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_iobf", {31'd0, io_buffer_full}, 32'd0);
    chk("rst_prog_done", {31'd0, prog_done}, 32'd0);
    chk("rst_overflow", {31'd0, tx_overflow}, 32'd0);

    // Counter snapshot: released at a falling edge, so the 512th rising edge sees 0x1FF.
    @(negedge clk);
    rst_in = 1'b1;
    repeat (511) @(negedge clk);
    mem_a = 32'h0003_0004; mem_wr = 1'b0;
    @(negedge clk);
    chk("cnt_b0", {24'd0, mem_din}, 32'hFF);
    mem_a = 32'h0003_0005;
    @(negedge clk);
    chk("cnt_b1", {24'd0, mem_din}, 32'h01);
    mem_a = 32'h0003_0006;
    @(negedge clk);
    chk("cnt_b2", {24'd0, mem_din}, 32'h00);
    mem_a = 32'h0003_0007;
    @(negedge clk);
    chk("cnt_b3", {24'd0, mem_din}, 32'h00);
    mem_a = Idle; mem_wr = 1'b1;

    // RAM: read-after-write on consecutive cycles, hold on non-read cycles.
    bus_wr(32'h0000_0011, 8'h5A);
    bus_wr(32'h0000_0010, 8'hA5);
    bus_rd(32'h0000_0010);
    chk("ram_raw", {24'd0, mem_din}, 32'hA5);
    @(negedge clk);
    chk("ram_hold", {24'd0, mem_din}, 32'hA5);
    bus_rd(32'h0000_0011);
    chk("ram_preload", {24'd0, mem_din}, 32'h5A);

    // 0x20010: aliases to 0x00010 by default, trapped when the OOB feature is enabled.
    bus_wr(32'h0002_0010, 8'h3C);
    bus_rd(32'h0000_0010);
`ifdef RAM_OOB_TRAP_EN
    chk("oob_wr_dropped", {24'd0, mem_din}, 32'hA5);
    bus_rd(32'h0002_0010);
    chk("oob_rd", {24'd0, mem_din}, 32'hFF);
    chk("oob_error", {31'd0, oob_error}, 32'd1);
`else
    chk("alias_wr", {24'd0, mem_din}, 32'h3C);
    bus_rd(32'h0002_0010);
    chk("alias_rd", {24'd0, mem_din}, 32'h3C);
`endif

    // TX with the UART always ready: 0x00 is filtered out.
    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h48);
    chk("tx_h_valid", {31'd0, tx_valid}, 32'd1);
    chk("tx_h_data", {24'd0, tx_data}, 32'h48);
    bus_wr(32'h0003_0000, 8'h00);
    chk("tx_zero_filtered", {31'd0, tx_valid}, 32'd0);
    bus_wr(32'h0003_0000, 8'h69);
    chk("tx_i_data", {24'd0, tx_data}, 32'h69);
    @(negedge clk);
    chk("tx_drained", {31'd0, tx_valid}, 32'd0);
    chk("tx_no_ovf", {31'd0, tx_overflow}, 32'd0);

    // TX fill with the UART stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_wr(32'h0003_0000, 8'(i));
    chk("iobf_at5", {31'd0, io_buffer_full}, 32'd0);
    bus_wr(32'h0003_0000, 8'h06);
    chk("iobf_at6", {31'd0, io_buffer_full}, 32'd1);
    bus_wr(32'h0003_0000, 8'h07);
    bus_wr(32'h0003_0000, 8'h08);
    chk("full_no_ovf", {31'd0, tx_overflow}, 32'd0);
    bus_wr(32'h0003_0000, 8'h09);
    chk("ovf_set", {31'd0, tx_overflow}, 32'd1);
    // Push and pop together on a full FIFO: 0x01 leaves, 0x0A enters.
    tx_ready = 1'b1;
    chk("tx_head_01", {24'd0, tx_data}, 32'h01);
    bus_wr(32'h0003_0000, 8'h0A);
    for (int i = 2; i <= 8; i++) begin
      chk("tx_drain", {24'd0, tx_data}, 32'(i));
      @(negedge clk);
    end
    chk("tx_drain_last", {24'd0, tx_data}, 32'h0A);
    @(negedge clk);
    chk("tx_empty", {31'd0, tx_valid}, 32'd0);
    chk("iobf_clear", {31'd0, io_buffer_full}, 32'd0);

    // RX: two bytes, then a read of an empty FIFO.
    rx_valid = 1'b1; rx_data = 8'h31;
    @(negedge clk);
    rx_data = 8'h32;
    @(negedge clk);
    rx_valid = 1'b0;
    bus_rd(32'h0003_0000);
    chk("rx_31", {24'd0, mem_din}, 32'h31);
    bus_rd(32'h0003_0000);
    chk("rx_32", {24'd0, mem_din}, 32'h32);
    bus_rd(32'h0003_0000);
    chk("rx_empty", {24'd0, mem_din}, 32'h00);

    // RX full: back-pressure and a rejected fifth byte.
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
    rx_data = 8'h45;
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_rd(32'h0003_0000);
      chk("rx_full_data", {24'd0, mem_din}, 32'h41 + 32'(i));
    end
    bus_rd(32'h0003_0000);
    chk("rx_reject", {24'd0, mem_din}, 32'h00);
    chk("rx_ready_back", {31'd0, rx_ready}, 32'd1);

    // Program stop emits 0x00 on TX.
    tx_ready = 1'b0;
    bus_wr(32'h0003_0004, 8'h77);
    chk("prog_done", {31'd0, prog_done}, 32'd1);
    chk("stop_valid", {31'd0, tx_valid}, 32'd1);
    chk("stop_byte", {24'd0, tx_data}, 32'h00);

    // Asynchronous reset in the middle of a read.
    rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    mem_a = 32'h0003_0000; mem_wr = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_rd", {24'd0, mem_din}, 32'h55);
    rst_in = 1'b0;
    #1;
    chk("arst_mem_din", {24'd0, mem_din}, 32'h00);
    chk("arst_prog_done", {31'd0, prog_done}, 32'd0);
    chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_overflow", {31'd0, tx_overflow}, 32'd0);
    mem_a = Idle; mem_wr = 1'b1;
    @(negedge clk);
    rst_in = 1'b1;
    bus_rd(32'h0003_0000);
    chk("post_rst_rx", {24'd0, mem_din}, 32'h00);
    bus_rd(32'h0000_0011);
    chk("ram_kept", {24'd0, mem_din}, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
